// File: rtl/upc_checkout_lane.sv
// Checkout-lane UPC scanner: classifies each accepted code against lookup masks,
// keeps saturating per-transaction tallies and locks the lane on a stolen item.
module upc_checkout_lane #(
  parameter int                      CODE_W      = 4,
  parameter logic [2**CODE_W-1:0]    DISC_MASK   = 16'hFCF0,
  parameter logic [2**CODE_W-1:0]    STOLEN_MASK = 16'h0501,
  parameter int                      CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_valid,
  input  logic [CODE_W-1:0] scan_code,
  output logic              scan_ready,
  input  logic              alarm_ack,
  input  logic              txn_clear,
  output logic              result_valid,
  output logic              discounted,
  output logic              stolen,
  output logic              alarm,
  output logic [CNT_W-1:0]  item_count,
  output logic [CNT_W-1:0]  disc_count,
  output logic [CNT_W-1:0]  stolen_count
);

  typedef enum logic {IDLE = 1'b0, ALARM = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               rv_q, rv_d;
  logic               disc_q, disc_d;
  logic               stol_q, stol_d;
  logic [CNT_W-1:0]   item_q, item_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;

  logic accept, cls_disc, cls_stol;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign scan_ready = (state_q == IDLE);
  assign accept     = scan_valid && scan_ready;
  assign cls_disc   = DISC_MASK[scan_code];
  assign cls_stol   = STOLEN_MASK[scan_code];

  always_comb begin
    state_d = state_q;
    rv_d    = accept;
    disc_d  = disc_q;
    stol_d  = stol_q;
    // txn_clear zeroes first so a same-cycle accept counts as item one
    item_d  = txn_clear ? '0 : item_q;
    dcnt_d  = txn_clear ? '0 : dcnt_q;
    scnt_d  = txn_clear ? '0 : scnt_q;
    if (accept) begin
      disc_d = cls_disc;
      stol_d = cls_stol;
      item_d = sat_inc(item_d);
      if (cls_disc) dcnt_d = sat_inc(dcnt_d);
      if (cls_stol) scnt_d = sat_inc(scnt_d);
    end
    case (state_q)
      IDLE:    if (accept && cls_stol) state_d = ALARM;
      ALARM:   if (alarm_ack)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rv_q    <= 1'b0;
      disc_q  <= 1'b0;
      stol_q  <= 1'b0;
      item_q  <= '0;
      dcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      disc_q  <= disc_d;
      stol_q  <= stol_d;
      item_q  <= item_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign alarm        = (state_q == ALARM);
  assign result_valid = rv_q;
  assign discounted   = disc_q;
  assign stolen       = stol_q;
  assign item_count   = item_q;
  assign disc_count   = dcnt_q;
  assign stolen_count = scnt_q;

endmodule
